// File: rtl/dsp_add_simd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_add_simd_pkg
//  Description : Shared constants, SIMD mode table and lane-packing helpers
//                for the DSP-slice SIMD adder family.
//  Revision    : 1.0 - initial release
// ============================================================================
package dsp_add_simd_pkg;

   localparam int c_alu_width = 48;

   typedef enum logic [1:0] {
      SIMD_ONE48  = 2'd0,
      SIMD_TWO24  = 2'd1,
      SIMD_FOUR12 = 2'd2
   } simd_mode_e;

   // Largest legal lane width per LANES setting; 0 marks an illegal LANES.
   function automatic int max_width(input int lanes);
      int result;
      case (lanes)
         1:       result = 48;
         2:       result = 24;
         3:       result = 12;
         default: result = 0;
      endcase
      return result;
   endfunction

   function automatic simd_mode_e simd_mode(input int lanes);
      simd_mode_e result;
      case (lanes)
         1:       result = SIMD_ONE48;
         2:       result = SIMD_TWO24;
         default: result = SIMD_FOUR12;
      endcase
      return result;
   endfunction

   function automatic int slot_width(input simd_mode_e mode);
      int result;
      case (mode)
         SIMD_ONE48: result = 48;
         SIMD_TWO24: result = 24;
         default:    result = 12;
      endcase
      return result;
   endfunction

   // Spread densely packed lanes (stride width) onto ALU slots (stride slot),
   // leaving every slot bit above the lane width at zero.
   function automatic logic [c_alu_width-1:0] pack_lanes(
      input logic [c_alu_width-1:0] data,
      input int                     lanes,
      input int                     width
   );
      logic [c_alu_width-1:0] mask;
      logic [c_alu_width-1:0] result;
      int                     slot;
      slot   = slot_width(simd_mode(lanes));
      mask   = (48'd1 << width) - 48'd1;
      result = '0;
      for (int i = 0; i < 3; i++) begin
         if (i < lanes) begin
            result = result | (((data >> (i * width)) & mask) << (i * slot));
         end
      end
      return result;
   endfunction

   // Inverse of pack_lanes: gather the low width bits of each slot.
   function automatic logic [c_alu_width-1:0] unpack_lanes(
      input logic [c_alu_width-1:0] alu,
      input int                     lanes,
      input int                     width
   );
      logic [c_alu_width-1:0] mask;
      logic [c_alu_width-1:0] result;
      int                     slot;
      slot   = slot_width(simd_mode(lanes));
      mask   = (48'd1 << width) - 48'd1;
      result = '0;
      for (int i = 0; i < 3; i++) begin
         if (i < lanes) begin
            result = result | (((alu >> (i * slot)) & mask) << (i * width));
         end
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_add.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_add
//  Description : Single-lane combinational adder wrapper around dsp_add_simd.
//  Revision    : 1.0 - initial release
// ============================================================================
module dsp_add #(
   parameter int width = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [width-1:0] a,
   input  logic [width-1:0] b,
   output logic [width-1:0] y
);

   dsp_add_simd #(
      .LANES (1),
      .WIDTH (width),
      .OREG  (0)
   ) u_core (
      .clock (clock),
      .reset (reset),
      .a     (a),
      .b     (b),
      .y     (y)
   );

endmodule
`default_nettype wire

// File: rtl/dsp_add_v2.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_add_v2
//  Description : Two-lane combinational adder wrapper around dsp_add_simd.
//  Revision    : 1.0 - initial release
// ============================================================================
module dsp_add_v2 #(
   parameter int width = 24
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [width-1:0] a0,
   input  logic [width-1:0] b0,
   input  logic [width-1:0] a1,
   input  logic [width-1:0] b1,
   output logic [width-1:0] y0,
   output logic [width-1:0] y1
);

   logic [2*width-1:0] w_y;

   dsp_add_simd #(
      .LANES (2),
      .WIDTH (width),
      .OREG  (0)
   ) u_core (
      .clock (clock),
      .reset (reset),
      .a     ({a1, a0}),
      .b     ({b1, b0}),
      .y     (w_y)
   );

   assign y0 = w_y[0     +: width];
   assign y1 = w_y[width +: width];

endmodule
`default_nettype wire

// File: rtl/dsp_add_v3.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_add_v3
//  Description : Three-lane combinational adder wrapper around dsp_add_simd.
//  Revision    : 1.0 - initial release
// ============================================================================
module dsp_add_v3 #(
   parameter int width = 12
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [width-1:0] a0,
   input  logic [width-1:0] b0,
   input  logic [width-1:0] a1,
   input  logic [width-1:0] b1,
   input  logic [width-1:0] a2,
   input  logic [width-1:0] b2,
   output logic [width-1:0] y0,
   output logic [width-1:0] y1,
   output logic [width-1:0] y2
);

   logic [3*width-1:0] w_y;

   dsp_add_simd #(
      .LANES (3),
      .WIDTH (width),
      .OREG  (0)
   ) u_core (
      .clock (clock),
      .reset (reset),
      .a     ({a2, a1, a0}),
      .b     ({b2, b1, b0}),
      .y     (w_y)
   );

   assign y0 = w_y[0       +: width];
   assign y1 = w_y[width   +: width];
   assign y2 = w_y[2*width +: width];

endmodule
`default_nettype wire

// File: rtl/dsp_add_simd.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_add_simd
//  Description : Carry-isolated multi-lane adder mapped onto one 48-bit
//                DSP ALU in SIMD mode, with optional output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module dsp_add_simd
   import dsp_add_simd_pkg::*;
#(
   parameter int LANES = 1,
   parameter int WIDTH = 8,
   parameter int OREG  = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [LANES*WIDTH-1:0] a,
   input  logic [LANES*WIDTH-1:0] b,
   output logic [LANES*WIDTH-1:0] y
);

   localparam int         c_bus   = LANES * WIDTH;
   localparam simd_mode_e c_mode  = simd_mode(LANES);
   localparam int         c_slot  = slot_width(c_mode);
   localparam int         c_slots = c_alu_width / c_slot;

   if ((LANES < 1) || (LANES > 3) || (WIDTH < 1) || (WIDTH > max_width(LANES))) begin : g_illegal
      $error("dsp_add_simd: illegal LANES=%0d / WIDTH=%0d combination", LANES, WIDTH);
   end

   logic [c_alu_width-1:0] w_alu_a;
   logic [c_alu_width-1:0] w_alu_b;
   logic [c_alu_width-1:0] w_alu_sum;
   logic [c_bus-1:0]       w_sum;

   assign w_alu_a = pack_lanes(c_alu_width'(a), LANES, WIDTH);
   assign w_alu_b = pack_lanes(c_alu_width'(b), LANES, WIDTH);

   // One adder per SIMD slot; the slot boundary is where the carry chain breaks.
   for (genvar s = 0; s < c_slots; s++) begin : g_slot
      assign w_alu_sum[s*c_slot +: c_slot] = w_alu_a[s*c_slot +: c_slot]
                                           + w_alu_b[s*c_slot +: c_slot];
   end

   assign w_sum = c_bus'(unpack_lanes(w_alu_sum, LANES, WIDTH));

   if (OREG != 0) begin : g_oreg
      logic [c_bus-1:0] r_y;
      always_ff @(posedge clock) begin
         if (reset) begin
            r_y <= '0;
         end else begin
            r_y <= w_sum;
         end
      end
      assign y = r_y;
   end else begin : g_comb
      logic w_unused_ctrl;
      assign w_unused_ctrl = clock ^ reset;
      assign y             = w_sum;
   end

endmodule
`default_nettype wire

// File: tb/tb_dsp_add_simd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dsp_add_simd
//  Description : Bench for dsp_add_simd corners and its dsp_add wrappers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_add_simd;

   localparam int c_n = 7;
   int ln [c_n] = '{1, 2, 3, 3, 1, 2, 3};
   int wd [c_n] = '{48, 24, 12, 12, 1, 1, 1};
   int og [c_n] = '{0, 1, 0, 1, 1, 0, 1};

   logic        clk = 1'b0;
   logic        rst;
   logic [47:0] a_all, b_all;
   int          n_tests = 0;
   int          n_fail  = 0;
   bit          chk_en  = 1'b0;
   bit          q_valid = 1'b0;
   logic [47:0] exp_q [c_n];
   logic [47:0] y_act [c_n];

   logic [47:0] y_u0;
   logic [47:0] y_u1;
   logic [35:0] y_u2, y_u3;
   logic [0:0]  y_u4;
   logic [1:0]  y_u5;
   logic [2:0]  y_u6;

   logic [7:0]  w8_a, w8_b, w8_y;
   logic [31:0] w32_a, w32_b, w32_y;
   logic [23:0] v2_a0, v2_b0, v2_a1, v2_b1, v2_y0, v2_y1;
   logic [11:0] v3_a0, v3_b0, v3_a1, v3_b1, v3_a2, v3_b2, v3_y0, v3_y1, v3_y2;

   always #5 clk = ~clk;

   dsp_add_simd #(.LANES(1), .WIDTH(48), .OREG(0)) u0 (.clock(clk), .reset(rst), .a(a_all),        .b(b_all),        .y(y_u0));
   dsp_add_simd #(.LANES(2), .WIDTH(24), .OREG(1)) u1 (.clock(clk), .reset(rst), .a(a_all),        .b(b_all),        .y(y_u1));
   dsp_add_simd #(.LANES(3), .WIDTH(12), .OREG(0)) u2 (.clock(clk), .reset(rst), .a(a_all[35:0]),  .b(b_all[35:0]),  .y(y_u2));
   dsp_add_simd #(.LANES(3), .WIDTH(12), .OREG(1)) u3 (.clock(clk), .reset(rst), .a(a_all[35:0]),  .b(b_all[35:0]),  .y(y_u3));
   dsp_add_simd #(.LANES(1), .WIDTH(1),  .OREG(1)) u4 (.clock(clk), .reset(rst), .a(a_all[0:0]),   .b(b_all[0:0]),   .y(y_u4));
   dsp_add_simd #(.LANES(2), .WIDTH(1),  .OREG(0)) u5 (.clock(clk), .reset(rst), .a(a_all[1:0]),   .b(b_all[1:0]),   .y(y_u5));
   dsp_add_simd #(.LANES(3), .WIDTH(1),  .OREG(1)) u6 (.clock(clk), .reset(rst), .a(a_all[2:0]),   .b(b_all[2:0]),   .y(y_u6));

   dsp_add    #(.width(8))  u_w8  (.clock(clk), .reset(rst), .a(w8_a),  .b(w8_b),  .y(w8_y));
   dsp_add    #(.width(32)) u_w32 (.clock(clk), .reset(rst), .a(w32_a), .b(w32_b), .y(w32_y));
   dsp_add_v2 #(.width(24)) u_v2  (.clock(clk), .reset(rst), .a0(v2_a0), .b0(v2_b0), .a1(v2_a1), .b1(v2_b1),
                                   .y0(v2_y0), .y1(v2_y1));
   dsp_add_v3 #(.width(12)) u_v3  (.clock(clk), .reset(rst), .a0(v3_a0), .b0(v3_b0), .a1(v3_a1), .b1(v3_b1),
                                   .a2(v3_a2), .b2(v3_b2), .y0(v3_y0), .y1(v3_y1), .y2(v3_y2));

   assign y_act[0] = y_u0;
   assign y_act[1] = y_u1;
   assign y_act[2] = 48'(y_u2);
   assign y_act[3] = 48'(y_u3);
   assign y_act[4] = 48'(y_u4);
   assign y_act[5] = 48'(y_u5);
   assign y_act[6] = 48'(y_u6);

   // Lane-wise (a_i + b_i) mod 2^width, using positional arithmetic on integers.
   function automatic logic [47:0] model(input logic [47:0] a, input logic [47:0] b,
                                         input int lanes, input int width);
      longint unsigned m, p, ua, ub, la, lb, r;
      m  = 64'd1 << width;
      p  = 64'd1;
      ua = 64'(a);
      ub = 64'(b);
      r  = 64'd0;
      for (int i = 0; i < lanes; i++) begin
         la = (ua / p) % m;
         lb = (ub / p) % m;
         r  = r + ((la + lb) % m) * p;
         p  = p * m;
      end
      return r[47:0];
   endfunction

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [47:0] rnd48();
      logic [47:0] v;
      case ($urandom_range(0, 7))
         0:       v = '0;
         1:       v = '1;
         default: v = 48'({$urandom(), $urandom()});
      endcase
      return v;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < c_n; k++) begin
         exp_q[k] <= rst ? 48'd0 : model(a_all, b_all, ln[k], wd[k]);
      end
      q_valid <= 1'b1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < c_n; k++) begin
            if ((og[k] == 0) || q_valid) begin
               check($sformatf("core_u%0d", k), y_act[k],
                     (og[k] != 0) ? exp_q[k] : model(a_all, b_all, ln[k], wd[k]));
            end
         end
      end
   end

   initial begin
      rst   = 1'b1;
      a_all = '0;
      b_all = '0;
      w8_a  = 8'hFF;       w8_b  = 8'h10;
      w32_a = 32'h00000001; w32_b = 32'hFFFF0001;
      v2_a0 = 24'hFFFFFF;  v2_b0 = 24'h000010;
      v2_a1 = 24'd23;      v2_b1 = 24'd7;
      v3_a0 = 12'd1;       v3_b0 = 12'hFF0;
      v3_a1 = 12'hFE9;     v3_b1 = 12'hFF9;
      v3_a2 = 12'd25;      v3_b2 = 12'd7;
      chk_en = 1'b1;

      check("model_pin_w8",   model(48'hFF, 48'h10, 1, 8), 48'h0F);
      check("model_pin_v2",   model(48'h000017_FFFFFF, 48'h000007_000010, 2, 24), 48'h00001E_00000F);
      check("model_pin_v3",   model(48'h019_FE9_001, 48'h007_FF9_FF0, 3, 12), 48'h020_FE2_FF1);

      @(negedge clk);
      check("reset_y_v2_oreg", y_act[1], 48'd0);
      check("reset_y_v3_oreg", y_act[3], 48'd0);
      rst   = 1'b0;
      a_all = 48'h000001_FFFFFF;
      b_all = 48'h000001_000001;
      check("w8_literal",  48'(w8_y),  48'h0F);
      check("w32_literal", 48'(w32_y), 48'hFFFF0002);
      check("v2_y0",       48'(v2_y0), 48'h00000F);
      check("v2_y1",       48'(v2_y1), 48'd30);
      check("v3_y0",       48'(v3_y0), 48'hFF1);
      check("v3_y1",       48'(v3_y1), 48'hFE2);
      check("v3_y2",       48'(v3_y2), 48'd32);
      @(negedge clk);
      check("v2_oreg_literal", y_act[1], 48'h000002_000000);

      repeat (1000) begin
         @(posedge clk);
         #1;
         rst   = ($urandom_range(0, 19) == 0);
         a_all = rnd48();
         b_all = rnd48();
         {w8_a, w32_a} = 40'(rnd48());
         {w8_b, w32_b} = 40'(rnd48());
         {v2_a1, v2_a0} = rnd48();
         {v2_b1, v2_b0} = rnd48();
         {v3_a2, v3_a1, v3_a0} = 36'(rnd48());
         {v3_b2, v3_b1, v3_b0} = 36'(rnd48());
         @(negedge clk);
         check("w8_rand",  48'(w8_y),  model(48'(w8_a),  48'(w8_b),  1, 8));
         check("w32_rand", 48'(w32_y), model(48'(w32_a), 48'(w32_b), 1, 32));
         check("v2_rand",  {v2_y1, v2_y0}, model({v2_a1, v2_a0}, {v2_b1, v2_b0}, 2, 24));
         check("v3_rand",  48'({v3_y2, v3_y1, v3_y0}),
               model(48'({v3_a2, v3_a1, v3_a0}), 48'({v3_b2, v3_b1, v3_b0}), 3, 12));
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
